// File: rtl/mem_sequencer_pkg.sv
// Shared encodings and defaults for the memory sequencer: request ops,
// FSM states, protection window defaults and ones'-complement constants.
package mem_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_RMW_INC = 2'd2,
        OP_RMW_DEC = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic [11:0] FIXED_BASE_DEF = 12'h400;
    localparam logic [11:0] REG_LIMIT_DEF  = 12'd17;
    localparam logic [15:0] OC_NEG_ZERO    = 16'hFFFF;
    localparam logic [15:0] OC_PLUS_ONE    = 16'h0001;
    localparam logic [15:0] OC_MINUS_ONE   = 16'hFFFE;

endpackage

// File: rtl/mem_sequencer_if.sv
// Bundle of the CPU request/response handshake and the memory-side bus.
// The master modport is the sequencer's view; slave is the CPU + memory side.
interface mem_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [2:0]  req_ebank;
    logic [4:0]  req_fbank;
    logic        req_super;
    logic [15:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic [15:0] rsp_faddr;
    logic        rsp_fault;

    logic [2:0]  mem_eBank;
    logic [4:0]  mem_fBank;
    logic        mem_superBank;
    logic [11:0] mem_address;
    logic [15:0] mem_dataIn;
    logic        mem_writeEnable;
    logic [15:0] mem_result;
    logic [15:0] mem_finalAddress;

    modport master (
        input  req_valid, req_op, req_addr, req_ebank, req_fbank, req_super, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_faddr, rsp_fault,
        input  rsp_ready,
        output mem_eBank, mem_fBank, mem_superBank, mem_address, mem_dataIn, mem_writeEnable,
        input  mem_result, mem_finalAddress
    );

    modport slave (
        output req_valid, req_op, req_addr, req_ebank, req_fbank, req_super, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_faddr, rsp_fault,
        output rsp_ready,
        input  mem_eBank, mem_fBank, mem_superBank, mem_address, mem_dataIn, mem_writeEnable,
        output mem_result, mem_finalAddress
    );

endinterface

// File: rtl/mem_sequencer_oc_add16.sv
// 16-bit ones'-complement adder: the carry out of bit 15 wraps back into bit 0.
module mem_sequencer_oc_add16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);

    logic [16:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum = w_raw[15:0] + {15'd0, w_raw[16]};

endmodule

// File: rtl/mem_sequencer.sv
// Single-outstanding bus master for the banked 16-bit memory: READ, WRITE and
// ones'-complement INC/DEC read-modify-write, with write protection.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int unsigned READ_WAIT  = 1,
    parameter logic [11:0] FIXED_BASE = FIXED_BASE_DEF,
    parameter logic [11:0] REG_LIMIT  = REG_LIMIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mem_sequencer_if.master bus
);

    localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT - 1);

    state_e      r_state;
    op_e         r_op;
    logic [2:0]  r_wait;
    logic        r_protect;
    logic [15:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic [15:0] r_rsp_faddr;
    logic        r_rsp_fault;
    logic [2:0]  r_ebank;
    logic [4:0]  r_fbank;
    logic        r_super;
    logic [11:0] r_addr;
    logic [15:0] r_data_in;
    logic        r_we;

    logic [15:0] w_addend;
    logic [15:0] w_sum;
    logic [15:0] w_new;

    assign w_addend = (r_op == OP_RMW_DEC) ? OC_MINUS_ONE : OC_PLUS_ONE;
    assign w_new    = (r_op == OP_WRITE) ? r_wdata : w_sum;

    mem_sequencer_oc_add16 u_add (
        .i_a   (bus.mem_result),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_wait      <= 3'd0;
            r_protect   <= 1'b0;
            r_wdata     <= 16'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
            r_rsp_faddr <= 16'd0;
            r_rsp_fault <= 1'b0;
            r_ebank     <= 3'd0;
            r_fbank     <= 5'd0;
            r_super     <= 1'b0;
            r_addr      <= 12'd0;
            r_data_in   <= 16'd0;
            r_we        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= op_e'(bus.req_op);
                        r_addr      <= bus.req_addr;
                        r_ebank     <= bus.req_ebank;
                        r_fbank     <= bus.req_fbank;
                        r_super     <= bus.req_super;
                        r_wdata     <= bus.req_wdata;
                        r_protect   <= (bus.req_addr >= FIXED_BASE) || (bus.req_addr < REG_LIMIT);
                        r_wait      <= 3'd0;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_rsp_faddr <= bus.mem_finalAddress;
                    // Faulted ops report the word as read; nothing is written.
                    if (r_op == OP_READ || r_protect) begin
                        r_rsp_rdata <= bus.mem_result;
                        r_rsp_fault <= r_protect && (r_op != OP_READ);
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_rsp_rdata <= w_new;
                        r_rsp_fault <= 1'b0;
                        r_data_in   <= w_new;
                        r_we        <= 1'b1;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.rsp_faddr       = r_rsp_faddr;
    assign bus.rsp_fault       = r_rsp_fault;
    assign bus.mem_eBank       = r_ebank;
    assign bus.mem_fBank       = r_fbank;
    assign bus.mem_superBank   = r_super;
    assign bus.mem_address     = r_addr;
    assign bus.mem_dataIn      = r_data_in;
    assign bus.mem_writeEnable = r_we;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer against a simple banked memory model whose
// final address is {0, eBank, memAddress}.
module tb_mem_sequencer;

    logic clk;
    logic reset;
    mem_sequencer_if bus();

    mem_sequencer #(.READ_WAIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:65535];
    int          we_cnt;
    logic [15:0] last_wdata;
    int          n_tot;
    int          n_bad;

    assign bus.mem_finalAddress = {1'b0, bus.mem_eBank, bus.mem_address};
    assign bus.mem_result       = mem[bus.mem_finalAddress];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_writeEnable) begin
            mem[bus.mem_finalAddress] <= bus.mem_dataIn;
            we_cnt     <= we_cnt + 1;
            last_wdata <= bus.mem_dataIn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [2:0] eb, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input logic exp_flt, input int exp_lat);
        int lat;
        int we0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_ebank = eb;
        bus.req_wdata = wd;
        we0 = we_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, {16'd0, bus.rsp_rdata}, {16'd0, exp_rd});
        chk({tag, "_fault"}, {31'd0, bus.rsp_fault}, {31'd0, exp_flt});
        chk({tag, "_faddr"}, {16'd0, bus.rsp_faddr}, {17'd0, eb, addr});
        chk({tag, "_wepulses"}, we_cnt - we0, (op != 2'd0 && !exp_flt) ? 1 : 0);
        @(negedge clk) bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int k;
        int we0;
        n_tot = 0;
        n_bad = 0;
        we_cnt = 0;
        last_wdata = 16'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
        mem[16'h0020] = 16'h1234;
        mem[16'h0100] = 16'h0000;
        mem[16'h0030] = 16'hFFFF;
        mem[16'h0031] = 16'h7FFE;
        mem[16'h0032] = 16'h0001;
        mem[16'h0400] = 16'hCAFE;
        mem[16'h0003] = 16'h0303;
        mem[16'h000B] = 16'h4014;
        mem[16'h0010] = 16'h0010;
        mem[16'h0011] = 16'h0005;
        mem[16'h03FF] = 16'h0000;
        mem[16'h3050] = 16'h5A5A;
        mem[16'h0200] = 16'h5555;

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = 12'd0;
        bus.req_ebank = 3'd0;
        bus.req_fbank = 5'd0;
        bus.req_super = 1'b0;
        bus.req_wdata = 16'd0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_writeEnable}, 32'd0);
        chk("rst_addr", {20'd0, bus.mem_address}, 32'd0);
        @(negedge clk) reset = 1'b0;

        do_req("rd020", 2'd0, 12'h020, 3'd0, 16'h0000, 16'h1234, 1'b0, 2);
        do_req("wr100", 2'd1, 12'h100, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 3);
        chk("wr100_data", {16'd0, last_wdata}, 32'h0000BEEF);
        do_req("rd100", 2'd0, 12'h100, 3'd0, 16'h0000, 16'hBEEF, 1'b0, 2);
        do_req("inc_ffff", 2'd2, 12'h030, 3'd0, 16'h0000, 16'h0001, 1'b0, 3);
        chk("inc_ffff_mem", {16'd0, mem[16'h0030]}, 32'h00000001);
        do_req("inc_7ffe", 2'd2, 12'h031, 3'd0, 16'h0000, 16'h7FFF, 1'b0, 3);
        chk("inc_7ffe_mem", {16'd0, mem[16'h0031]}, 32'h00007FFF);
        do_req("dec_0001", 2'd3, 12'h032, 3'd0, 16'h0000, 16'hFFFF, 1'b0, 3);
        chk("dec_0001_mem", {16'd0, mem[16'h0032]}, 32'h0000FFFF);
        do_req("wr400", 2'd1, 12'h400, 3'd0, 16'h1111, 16'hCAFE, 1'b1, 2);
        chk("wr400_mem", {16'd0, mem[16'h0400]}, 32'h0000CAFE);
        do_req("wr003", 2'd1, 12'h003, 3'd0, 16'h2222, 16'h0303, 1'b1, 2);
        chk("wr003_mem", {16'd0, mem[16'h0003]}, 32'h00000303);
        do_req("rd00b", 2'd0, 12'h00B, 3'd0, 16'h0000, 16'h4014, 1'b0, 2);
        do_req("inc010", 2'd2, 12'h010, 3'd0, 16'h0000, 16'h0010, 1'b1, 2);
        do_req("inc011", 2'd2, 12'h011, 3'd0, 16'h0000, 16'h0006, 1'b0, 3);
        do_req("wr3ff", 2'd1, 12'h3FF, 3'd0, 16'h00AB, 16'h00AB, 1'b0, 3);
        do_req("rd_eb3", 2'd0, 12'h050, 3'd3, 16'h0000, 16'h5A5A, 1'b0, 2);

        // Back-pressure: response held while another request waits.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_addr  = 12'h00B;
        bus.req_ebank = 3'd0;
        @(posedge clk);
        #1 bus.req_addr = 12'h020;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk("bp_first_lat", k, 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_rdata", {16'd0, bus.rsp_rdata}, 32'h00004014);
        end
        chk("bp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
        @(negedge clk) bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk("bp_idle_after_hs", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("bp_second_accept", {31'd0, bus.req_ready}, 32'd0);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk("bp_second_lat", k, 2);
        chk("bp_second_rdata", {16'd0, bus.rsp_rdata}, 32'h00001234);
        @(negedge clk) bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;

        // Reset while the write strobe is high.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_addr  = 12'h200;
        bus.req_ebank = 3'd0;
        bus.req_wdata = 16'hAAAA;
        we0 = we_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k = 0;
        while (!bus.mem_writeEnable && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk("rstw_we_seen", {31'd0, bus.mem_writeEnable}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstw_we", {31'd0, bus.mem_writeEnable}, 32'd0);
        chk("rstw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstw_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_mem", {16'd0, mem[16'h0200]}, 32'h00005555);
        chk("rstw_wecnt", we_cnt - we0, 0);
        do_req("rd200", 2'd0, 12'h200, 3'd0, 16'h0000, 16'h5555, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Initiator-side bus master for the banked 16-bit memory block.
- Accepts one CPU request at a time: READ, WRITE, or ones'-complement read-modify-write (INC/DEC).
- Drives the memory's bank, address, data and write-enable inputs, then samples its combinational result and final-address outputs.
- Returns a single response with data and a fault flag. Writes to fixed memory or to the register-mapped window are blocked.

Parameters:
- READ_WAIT, 1, cycles the address is held before result/finalAddress are sampled (1..7).
- FIXED_BASE, 12'h400, first memAddress treated as fixed (read-only) memory.
- REG_LIMIT, 17, memAddress values below this are register-mapped and write-protected.

Ports:
- clk  in  1  system clock, rising edge. The block has one clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle, can accept a request.
- req_op  in  2  0=READ, 1=WRITE, 2=RMW_INC, 3=RMW_DEC.
- req_addr  in  12  memAddress of request.
- req_ebank  in  3  erasable bank.
- req_fbank  in  5  fixed bank.
- req_super  in  1  superbank bit.
- req_wdata  in  16  write data (WRITE only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  16  see Behaviour.
- rsp_faddr  out  16  finalAddress sampled for this access.
- rsp_fault  out  1  write/RMW blocked by protection.
- mem_eBank  out  3  to memory eBank.
- mem_fBank  out  5  to memory fBank.
- mem_superBank  out  1  to memory superBank.
- mem_address  out  12  to memory memAddress.
- mem_dataIn  out  16  to memory dataIn.
- mem_writeEnable  out  1  to memory writeEnable.
- mem_result  in  16  memory result.
- mem_finalAddress  in  16  memory finalAddress.

Behaviour:
- Reset values: req_ready=1; rsp_valid=0; all other outputs 0; FSM=IDLE; wait counter 0.
- Reset mid-transaction aborts it immediately. mem_writeEnable drops asynchronously and no write completes.
- FSM states: IDLE, ADDR, SAMPLE, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1 at a rising edge: latch op, addr, banks, wdata; go to ADDR.
  - protect = (addr >= FIXED_BASE) || (addr < REG_LIMIT), computed at accept.
- ADDR:
  - mem_* address/bank outputs drive the latched values.
  - These outputs stay stable from ADDR through WRITE.
  - Stay READ_WAIT cycles, then go to SAMPLE.
- SAMPLE (one cycle):
  - Capture mem_result into old and mem_finalAddress into rsp_faddr.
  - READ, or any op with protect=1: go to RESP.
  - Otherwise: go to WRITE.
- WRITE (exactly one cycle):
  - mem_writeEnable=1, mem_dataIn=new; then go to RESP.
  - new = req_wdata for WRITE.
  - RMW_INC: s = old + 16'h0001 (17-bit); new = s[15:0] + s[16] (end-around carry).
  - RMW_DEC: same as INC with addend 16'hFFFE.
- RESP:
  - rsp_valid=1; rdata/faddr/fault held stable until rsp_ready=1 at a rising edge, then go to IDLE.
  - rsp_rdata = old for READ and for faulted ops; rsp_rdata = new otherwise.
  - rsp_fault = protect && op != READ.
- req_ready=0 in every state except IDLE. A request presented while busy is not consumed.
- Latency with READ_WAIT=1: accept edge E, rsp_valid high after E+2 (READ/faulted) or E+3 (write/RMW). Each extra READ_WAIT adds one cycle.
- Back-to-back throughput: a new request can be accepted on the edge after rsp_ready handshake.
- mem_writeEnable is never asserted outside WRITE, never for READ, and never when protect=1.

Decomposition:
- Shared package/include mem_defs: op encodings, FSM state encodings, FIXED_BASE/REG_LIMIT defaults, and the OC_NEG_ZERO=16'hFFFF constant.
- One natural sub-module, oc_add16: combinational 16-bit ones'-complement adder with end-around carry, reusable by the ALU.

Test Plan:
- READ addr 12'h020, eBank 0, memory word 16'h1234 -> rsp_valid at E+2, rsp_rdata=16'h1234, rsp_fault=0, mem_writeEnable never high.
- WRITE addr 12'h100, wdata 16'hBEEF -> exactly one mem_writeEnable pulse with mem_dataIn=16'hBEEF, rsp_rdata=16'hBEEF; a following READ of 12'h100 returns 16'hBEEF.
- RMW_INC on 16'hFFFF -> writes 16'h0001. RMW_INC on 16'h7FFE -> writes 16'h7FFF. RMW_DEC on 16'h0001 -> writes 16'hFFFF.
- WRITE to 12'h400 and to 12'h003 -> rsp_fault=1, no write-enable pulse, rsp_rdata = value read (16'h4014 from 12'h00B for a READ check).
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0 throughout, response fields unchanged, second request accepted one edge after rsp_ready=1.
- Assert reset during WRITE -> mem_writeEnable=0 and rsp_valid=0 immediately, req_ready=1, target word unchanged.
